// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO sequencer: iterative mult/multu/div/divu, one bit per cycle, with
// sign fix-up and pipeline stall generation for mfhi/mflo and back-to-back ops.
module hilo_muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] OperandA,
    input  logic [DATA_WIDTH-1:0] OperandB,
    input  logic                  HiLoRead,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Stall,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_load;
    logic   w_commit;

    logic          r_is_div;
    logic          r_sign_a;
    logic          r_sign_b;
    logic          r_bzero;
    logic [W-1:0]  r_raw_a;
    logic [W-1:0]  r_shift;
    logic [W-1:0]  r_mag_b;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic          r_done;
    logic          r_dbz;

    logic          w_signed;
    logic          w_neg_a;
    logic          w_neg_b;
    logic [W-1:0]  w_mag_a;
    logic [W-1:0]  w_mag_b;

    logic [2*W-1:0] w_addend;
    logic [2*W-1:0] w_mul_acc;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_div_acc;

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_res_hi;
    logic [W-1:0]   w_res_lo;

    // Operand capture: magnitudes for signed ops, raw values for unsigned ones
    assign w_signed = ~Op[0];
    assign w_neg_a  = w_signed & OperandA[W-1];
    assign w_neg_b  = w_signed & OperandB[W-1];
    assign w_mag_a  = w_neg_a ? -OperandA : OperandA;
    assign w_mag_b  = w_neg_b ? -OperandB : OperandB;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start && !Flush) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (Flush) begin
                    w_next = S_IDLE;
                end else if (r_count == '0) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next   = S_IDLE;
                w_commit = !Flush;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Multiply consumes multiplier bits MSB-first: acc = 2*acc + bit*mcand
    assign w_addend  = r_shift[W-1] ? {{W{1'b0}}, r_mag_b} : '0;
    assign w_mul_acc = {r_acc[2*W-2:0], 1'b0} + w_addend;

    // Restoring divide: remainder in acc upper half, quotient shifts into lower half
    assign w_rem_sh  = {r_acc[2*W-1:W], r_shift[W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_mag_b};
    assign w_div_acc = w_diff[W] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                                 : {w_diff[W-1:0],   r_acc[W-2:0], 1'b1};

    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quot = r_acc[W-1:0];
    assign w_rem  = r_acc[2*W-1:W];

    always_comb begin
        w_res_hi = w_prod[2*W-1:W];
        w_res_lo = w_prod[W-1:0];
        if (r_is_div) begin
            if (r_bzero) begin
                w_res_hi = r_raw_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = r_sign_a ? -w_rem : w_rem;
                w_res_lo = (r_sign_a ^ r_sign_b) ? -w_quot : w_quot;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_bzero  <= 1'b0;
            r_raw_a  <= '0;
            r_shift  <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_dbz  <= w_commit & r_is_div & r_bzero;
            if (w_load) begin
                r_is_div <= Op[1];
                r_sign_a <= w_neg_a;
                r_sign_b <= w_neg_b;
                r_bzero  <= (OperandB == '0);
                r_raw_a  <= OperandA;
                r_shift  <= w_mag_a;
                r_mag_b  <= w_mag_b;
                r_acc    <= '0;
                r_count  <= LAST;
            end else if (r_state == S_RUN) begin
                r_acc   <= r_is_div ? w_div_acc : w_mul_acc;
                r_shift <= {r_shift[W-2:0], 1'b0};
                r_count <= r_count - CW'(1);
            end
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign Busy      = (r_state != S_IDLE);
    assign Stall     = Busy & (Start | HiLoRead);
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign HI        = r_hi;
    assign LO        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Bench for hilo_muldiv_sequencer: arithmetic reference model compared every
// cycle, plus directed cases with hand-computed results.
module tb_hilo_muldiv_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        HiLoRead;
    logic        Flush;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic        DivByZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    hilo_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .HiLoRead  (HiLoRead),
        .Flush     (Flush),
        .Busy      (Busy),
        .Stall     (Stall),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI        (HI),
        .LO        (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic
    function automatic void calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd1: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = '1;
                    dz = 1'b1;
                end else if (op == 2'd2) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hi = r[31:0];
                    lo = q[31:0];
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
        endcase
    endfunction

    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_dbz   = 1'b0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic [31:0] p_hi, p_lo;
    logic        p_dz;
    int          m_left  = 0;

    // Model: an accepted op commits 33 edges later unless flushed or reset
    initial begin
        forever begin
            @(posedge Clk);
            if (Reset) begin
                m_valid = 1'b1;
                m_busy  = 1'b0;
                m_done  = 1'b0;
                m_dbz   = 1'b0;
                m_hi    = '0;
                m_lo    = '0;
            end else begin
                m_done = 1'b0;
                m_dbz  = 1'b0;
                if (m_busy) begin
                    if (Flush) begin
                        m_busy = 1'b0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_busy = 1'b0;
                            m_hi   = p_hi;
                            m_lo   = p_lo;
                            m_done = 1'b1;
                            m_dbz  = p_dz;
                        end
                    end
                end else if (Start && !Flush) begin
                    calc(Op, OperandA, OperandB, p_hi, p_lo, p_dz);
                    m_busy = 1'b1;
                    m_left = 33;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (m_valid) begin
                chk1 ("busy",  Busy,      m_busy);
                chk1 ("stall", Stall,     m_busy & (Start | HiLoRead));
                chk1 ("done",  Done,      m_done);
                chk1 ("dbz",   DivByZero, m_dbz);
                chk32("hi",    HI,        m_hi);
                chk32("lo",    LO,        m_lo);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n;
        n = 0;
        while (Done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk32({name, "_latency"}, n, exp_lat);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        Op       = op;
        OperandA = a;
        OperandB = b;
        Start    = 1'b1;
        tick();
        Start    = 1'b0;
        OperandA = $urandom;
        OperandB = $urandom;
        wait_done(name, 33);
        chk32({name, "_hi"}, HI, ehi);
        chk32({name, "_lo"}, LO, elo);
        chk1 ({name, "_dbz"}, DivByZero, edz);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Op       = 2'd0;
        OperandA = '0;
        OperandB = '0;
        HiLoRead = 1'b0;
        Flush    = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        chk1 ("reset_busy", Busy, 1'b0);
        chk1 ("reset_done", Done, 1'b0);
        chk32("reset_hi",   HI,   32'd0);
        chk32("reset_lo",   LO,   32'd0);

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", 2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_zero_s",2'd2, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

        // mfhi/mflo held behind a running mult
        Op = 2'd0; OperandA = 32'd5; OperandB = 32'd7; Start = 1'b1;
        tick();
        Start    = 1'b0;
        HiLoRead = 1'b1;
        chk1("stall_hilo", Stall, 1'b1);
        wait_done("stall", 33);
        chk1 ("stall_done_cycle", Stall, 1'b0);
        chk32("stall_lo", LO, 32'd35);
        tick();
        chk1("stall_idle_read", Stall, 1'b0);
        HiLoRead = 1'b0;

        // Back-to-back: second op held during Busy, accepted in the Done cycle
        Op = 2'd1; OperandA = 32'd3; OperandB = 32'd4; Start = 1'b1;
        tick();
        OperandA = 32'd7; OperandB = 32'd6;
        chk1("b2b_stall", Stall, 1'b1);
        wait_done("b2b_first", 33);
        chk32("b2b_first_lo", LO, 32'd12);
        tick();
        Start = 1'b0;
        wait_done("b2b_second", 33);
        chk32("b2b_second_hi", HI, 32'd0);
        chk32("b2b_second_lo", LO, 32'h2A);

        // Reset partway through a divide
        Op = 2'd2; OperandA = 32'd100; OperandB = 32'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (8) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk1 ("rst_mid_busy", Busy, 1'b0);
        chk1 ("rst_mid_done", Done, 1'b0);
        chk32("rst_mid_hi",   HI,   32'd0);
        chk32("rst_mid_lo",   LO,   32'd0);
        repeat (40) tick();

        // Flush partway through a mult keeps the previous HI/LO
        run_op("pre_flush", 2'd1, 32'd7, 32'd6, 32'd0, 32'h2A, 1'b0);
        Op = 2'd0; OperandA = 32'hFFFF_FFFD; OperandB = 32'd9; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk1("flush_busy", Busy, 1'b0);
        repeat (40) tick();
        chk32("flush_hi", HI, 32'd0);
        chk32("flush_lo", LO, 32'h2A);

        // Start with Flush in the same cycle is dropped
        Start = 1'b1; Flush = 1'b1;
        tick();
        Start = 1'b0; Flush = 1'b0;
        chk1("start_flush_ignored", Busy, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            Start    = ($urandom_range(2) != 0);
            Op       = 2'($urandom_range(3));
            OperandA = rand_operand();
            OperandB = rand_operand();
            HiLoRead = $urandom_range(1) == 1;
            Flush    = ($urandom_range(59) == 0);
            Reset    = ($urandom_range(699) == 0);
            tick();
        end
        Start = 1'b0; Flush = 1'b0; Reset = 1'b0; HiLoRead = 1'b0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
